mult_iter_booth4: RTL
=====================

# mult_iter_booth4

Parametrised iterative radix-4 Booth multiplier with a valid/ready handshake on input and output. It computes the full 2·WIDTH-bit product of two WIDTH-bit operands, either unsigned or two's-complement, retiring one Booth digit per cycle. It replaces fixed-width combinational partial-product trees wherever area matters more than latency. It sits between an operand-issue stage and a result-consume stage that may stall.

## Interface
- WIDTH, 8, operand width; must be even and ≥4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned. Present only with MULT_SIGNED_EN.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer takes product.
- o  output  2·WIDTH  product.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch x, y and is_signed, clear the accumulator, load the digit counter with N=WIDTH/2+1, and go to CALC.
- Operand extension: x is extended to WIDTH+2 bits and y to WIDTH+2 bits, plus an implicit 0 below the LSB. Extension is sign extension when is_signed=1 and zero extension otherwise.
- CALC, one Booth digit per cycle, LSB digit first:
  - digit = −2·y[i+1] + y[i] + y[i−1], giving a value in {−2,−1,0,+1,+2}.
  - Add digit·x, shifted left by 2·(digit index), to a 2·WIDTH+2-bit accumulator; modular arithmetic.
  - After N digits go to DONE.
- DONE: out_valid=1. o is the low 2·WIDTH bits of the accumulator and equals the exact product for both modes. Leave DONE on out_valid&&out_ready and go to IDLE.
- o and out_valid are registered. o holds its value in DONE and while out_ready is low.
- in_valid outside IDLE is ignored. The latched operands do not change when x or y move during CALC.
- An input accept and an output handshake never occur in the same cycle, because in_ready=0 in DONE.

## Timing
- Reset values: in_ready=1, out_valid=0, o=0, state=IDLE, counter=0, accumulator=0.
- Accept on edge k. CALC occupies edges k+1 … k+N. out_valid rises after edge k+N.
  - WIDTH=8 gives N=5, so out_valid is high in the cycle after edge k+5.
- If out_ready=1 when out_valid first rises, the handshake completes on the next edge and in_ready is 1 after it.
- Minimum issue interval: N+2 cycles.
- rst_n low at any time, including mid-CALC or mid-DONE, immediately forces all reset values. The product in flight is discarded. The first accept after release is processed normally.
- out_ready is sampled only in DONE. out_ready=1 in IDLE or CALC has no effect.

## Configuration
- MULT_SIGNED_EN defined: the is_signed port exists and both modes work as specified.
- MULT_SIGNED_EN undefined:
  - The is_signed port is absent and the block is unsigned-only; extension is always zero extension.
  - N stays WIDTH/2+1 and latency is unchanged.

## Test plan
- Unsigned, WIDTH=8: x=255, y=255 -> o=0xFE01 after 5 CALC cycles; out_valid one cycle; in_ready returns.
- Signed, WIDTH=8 (MULT_SIGNED_EN): (x,y) = (0x80,0x80) -> o=0x4000; (0xFF,0x01) -> o=0xFFFF; (0x7F,0x80) -> o=0xC080.
- Backpressure: hold out_ready=0 for 6 cycles in DONE. o and out_valid must stay stable and in_ready=0. Raise out_ready -> one handshake, then in_ready=1.
- Ignored input: toggle in_valid, x and y during CALC. The result must match the first accepted operands only, with no extra accept.
- Reset mid-operation: assert rst_n=0 on the third CALC cycle -> outputs go to reset values at once. Then x=3, y=5 -> o=15.
- Exhaustive at WIDTH=4, both modes: all 256 operand pairs -> o equals the reference product x·y (signed or unsigned), with random out_ready stalls.

Source files
------------

// File: rtl/mult_iter_booth4_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_iter_booth4_if                                             |
// | Brief    : Operand-issue / result-consume handshake bundle for the         |
// |            iterative Booth multiplier. is_signed exists with MULT_SIGNED_EN.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mult_iter_booth4_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     x;
   logic [WIDTH-1:0]     y;
`ifdef MULT_SIGNED_EN
   logic                 is_signed;
`endif
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   o;

   modport master (
`ifdef MULT_SIGNED_EN
      output is_signed,
`endif
      output in_valid, x, y, out_ready,
      input  in_ready, out_valid, o
   );

   modport slave (
`ifdef MULT_SIGNED_EN
      input  is_signed,
`endif
      input  in_valid, x, y, out_ready,
      output in_ready, out_valid, o
   );
endinterface
`default_nettype wire

// File: rtl/mult_iter_booth4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mult_iter_booth4                                                |
// | Brief    : Iterative radix-4 Booth multiplier, one digit per cycle, with   |
// |            valid/ready in and out. MULT_SIGNED_EN adds two's-complement.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mult_iter_booth4 #(
   parameter int WIDTH = 8
) (
   input wire                clk,
   input wire                rst_n,
   mult_iter_booth4_if.slave bus
);
   localparam int c_ndig = WIDTH / 2 + 1;
   localparam int c_aw   = 2 * WIDTH + 2;
   localparam int c_yw   = WIDTH + 3;
   localparam int c_cw   = $clog2(c_ndig + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [c_aw-1:0]     r_acc;
   logic [c_aw-1:0]     r_xsh;
   logic [c_yw-1:0]     r_y;
   logic [c_cw-1:0]     r_cnt;
   logic [2*WIDTH-1:0]  r_o;
   logic                r_out_valid;
   logic [c_aw-1:0]     w_pp;
   logic [c_aw-1:0]     w_acc_next;
   logic [c_aw-1:0]     w_x_ext;
   logic [c_yw-1:0]     w_y_ext;
   logic                w_sgn;
   logic                w_last;
   logic                w_in_ready;

`ifdef MULT_SIGNED_EN
   assign w_sgn = bus.is_signed;
`else
   assign w_sgn = 1'b0;
`endif

   // y carries the implicit zero below its LSB so digit i reads r_y[2:0] after i shifts
   assign w_x_ext = {{(c_aw - WIDTH){w_sgn & bus.x[WIDTH-1]}}, bus.x};
   assign w_y_ext = {{2{w_sgn & bus.y[WIDTH-1]}}, bus.y, 1'b0};
   assign w_last  = (r_cnt == c_cw'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_next = S_CALC;
         end
         S_CALC: begin
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Booth digit selection: multiples of the already-shifted multiplicand
   always_comb begin
      w_pp = '0;
      case (r_y[2:0])
         3'b001, 3'b010: w_pp = r_xsh;
         3'b011:         w_pp = r_xsh << 1;
         3'b100:         w_pp = -(r_xsh << 1);
         3'b101, 3'b110: w_pp = -r_xsh;
         default:        w_pp = '0;
      endcase
   end

   assign w_acc_next = r_acc + w_pp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_xsh       <= '0;
         r_y         <= '0;
         r_cnt       <= '0;
         r_o         <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_acc <= '0;
                  r_xsh <= w_x_ext;
                  r_y   <= w_y_ext;
                  r_cnt <= c_cw'(c_ndig);
               end
            end
            S_CALC: begin
               r_acc <= w_acc_next;
               r_xsh <= r_xsh << 2;
               r_y   <= {2'b00, r_y[c_yw-1:2]};
               r_cnt <= r_cnt - c_cw'(1);
               if (w_last) begin
                  r_out_valid <= 1'b1;
                  r_o         <= w_acc_next[2*WIDTH-1:0];
               end
            end
            S_DONE: begin
               if (bus.out_ready) r_out_valid <= 1'b0;
            end
            default: r_out_valid <= 1'b0;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.o         = r_o;

endmodule
`default_nettype wire
